// File: rtl/seg_pipe_adder_pkg.sv
// Shared defaults and helpers for the segmented pipelined adder.
// Saturation constants are only consumed when SEG_PIPE_ADDER_SAT_EN is defined.
package seg_pipe_adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG   = 8;
    localparam int SAT_W     = 64;

    function automatic int calc_nseg(input int w, input int s);
        return w / s;
    endfunction

    function automatic logic [SAT_W-1:0] sat_max(input int w);
        return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    endfunction

    function automatic logic [SAT_W-1:0] sat_min(input int w);
        return SAT_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/seg_adder_stage.sv
// One SEG-bit slice of the pipelined adder: registered sum, carry and
// the signed-overflow flag of this slice's MSB.
module seg_adder_stage #(
    parameter int SEG = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_en,
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_c,
    output logic [SEG-1:0] o_sum,
    output logic           o_c,
    output logic           o_ovf
);

    logic [SEG:0] w_sum;
    logic         w_ovf;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_c};
    assign w_ovf = (i_a[SEG-1] == i_b[SEG-1]) &&
                   (w_sum[SEG-1] != i_a[SEG-1]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sum <= '0;
            o_c   <= 1'b0;
            o_ovf <= 1'b0;
        end else if (i_en) begin
            o_sum <= w_sum[SEG-1:0];
            o_c   <= w_sum[SEG];
            o_ovf <= w_ovf;
        end
    end

endmodule

// File: rtl/seg_pipe_adder.sv
// WIDTH-bit add/sub resolved one SEG-bit segment per stage, valid/ready.
// Define SEG_PIPE_ADDER_SAT_EN to saturate the sum on signed overflow.
module seg_pipe_adder
    import seg_pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = calc_nseg(WIDTH, SEG);

    if (WIDTH % SEG != 0 || NSEG < 1) begin : g_bad_cfg
        $error("seg_pipe_adder: WIDTH must be a multiple of SEG");
    end

    logic             w_en;
    logic [WIDTH-1:0] w_beff;
    logic             w_c0;
    logic [WIDTH-1:0] w_raw;

    logic             r_v   [NSEG];
    logic [WIDTH-1:0] r_a   [NSEG];
    logic [WIDTH-1:0] r_b   [NSEG];
    logic [WIDTH-1:0] r_lo  [NSEG];
    logic [WIDTH-1:0] w_sa  [NSEG];
    logic [WIDTH-1:0] w_sb  [NSEG];
    logic [SEG-1:0]   w_seg [NSEG];
    logic             w_ic  [NSEG];
    logic             w_c   [NSEG];
    logic             w_ovf [NSEG];

    assign w_en      = !out_valid || out_ready;
    assign in_ready  = w_en;
    assign w_beff    = sub ? ~b : b;
    assign w_c0      = sub | cin;
    assign out_valid = r_v[NSEG-1];
    assign cout      = w_c[NSEG-1];
    assign ovf       = w_ovf[NSEG-1];

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_sa[k] = a;
            assign w_sb[k] = w_beff;
            assign w_ic[k] = w_c0;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)     r_v[k] <= 1'b0;
                else if (w_en) r_v[k] <= in_valid;
            end
        end else begin : g_next
            assign w_sa[k] = r_a[k-1];
            assign w_sb[k] = r_b[k-1];
            assign w_ic[k] = w_c[k-1];
            always_ff @(posedge clk or posedge reset) begin
                if (reset)     r_v[k] <= 1'b0;
                else if (w_en) r_v[k] <= r_v[k-1];
            end
        end

        // Unprocessed high segments shift down so segment 0 is always next.
        if (k < NSEG - 1) begin : g_skew
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_a[k] <= '0;
                    r_b[k] <= '0;
                end else if (w_en) begin
                    r_a[k] <= w_sa[k] >> SEG;
                    r_b[k] <= w_sb[k] >> SEG;
                end
            end
        end

        // Completed segments enter at the top and shift down each stage.
        if (k == 1) begin : g_lo_first
            always_ff @(posedge clk or posedge reset) begin
                if (reset)     r_lo[k] <= '0;
                else if (w_en) r_lo[k] <= {w_seg[0], {(WIDTH-SEG){1'b0}}};
            end
        end else if (k > 1) begin : g_lo_next
            always_ff @(posedge clk or posedge reset) begin
                if (reset)     r_lo[k] <= '0;
                else if (w_en) r_lo[k] <= {w_seg[k-1], r_lo[k-1][WIDTH-1:SEG]};
            end
        end

        seg_adder_stage #(
            .SEG (SEG)
        ) u_stage (
            .i_clk (clk),
            .i_rst (reset),
            .i_en  (w_en),
            .i_a   (w_sa[k][SEG-1:0]),
            .i_b   (w_sb[k][SEG-1:0]),
            .i_c   (w_ic[k]),
            .o_sum (w_seg[k]),
            .o_c   (w_c[k]),
            .o_ovf (w_ovf[k])
        );
    end

    if (NSEG == 1) begin : g_raw_one
        assign w_raw = w_seg[0];
    end else begin : g_raw_many
        assign w_raw = {w_seg[NSEG-1], r_lo[NSEG-1][WIDTH-1:SEG]};
    end

`ifdef SEG_PIPE_ADDER_SAT_EN
    localparam logic [SAT_W-1:0] SAT_MAX_C = sat_max(WIDTH);
    localparam logic [SAT_W-1:0] SAT_MIN_C = sat_min(WIDTH);

    if (WIDTH > SAT_W) begin : g_bad_sat
        $error("seg_pipe_adder: saturation limited to SAT_W bits");
    end

    logic r_amsb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     r_amsb <= 1'b0;
        else if (w_en) r_amsb <= w_sa[NSEG-1][SEG-1];
    end

    assign sum = !ovf   ? w_raw :
                 r_amsb ? SAT_MIN_C[WIDTH-1:0] : SAT_MAX_C[WIDTH-1:0];
`else
    assign sum = w_raw;
`endif

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Self-checking bench for seg_pipe_adder (WIDTH=32, SEG=8, latency 4).
// Reference model is plain 64-bit arithmetic plus an in-order queue.
module tb_seg_pipe_adder;

    localparam int W   = 32;
    localparam int LAT = 4;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct {
        logic [33:0] r;
        int          t;
    } ent_t;

    ent_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   chk_lat = 1'b0;

    always #5 clk = ~clk;

    seg_pipe_adder #(
        .WIDTH (32),
        .SEG   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic sb);
        logic [31:0] be;
        logic [63:0] u;
        longint      s;
        logic        c0;
        logic        ov;
        logic [31:0] r;
        be = sb ? ~y : y;
        c0 = sb ? 1'b1 : ci;
        u  = {32'd0, x} + {32'd0, be} + {63'd0, c0};
        s  = longint'($signed(x)) + longint'($signed(be)) + longint'({63'd0, c0});
        ov = (s > SMAX) || (s < SMIN);
        r  = u[31:0];
`ifdef SEG_PIPE_ADDER_SAT_EN
        if (ov) r = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {ov, u[32], r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic tick(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic ic, input logic is, input logic ordy,
                        input bit ux, input logic [33:0] xp, output bit acc);
        ent_t e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = ic;
        sub       = is;
        out_ready = ordy;
        #1;
        chk("in_ready", 64'(in_ready), 64'(!(out_valid && !ordy)));
        if (chk_lat)
            chk("out_valid_timing", 64'(out_valid),
                64'(q.size() > 0 && q[0].t + LAT == cyc));
        if (out_valid && ordy) begin
            if (q.size() == 0) begin
                chk("extra_result", 64'(out_valid), 64'd0);
            end else begin
                e = q.pop_front();
                chk("result", 64'({ovf, cout, sum}), 64'(e.r));
            end
        end
        acc = iv && in_ready;
        if (acc) begin
            e.r = ux ? xp : model(ia, ib, ic, is);
            e.t = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        int          n;
        int          guard;
        logic [31:0] ra, rb;
        logic        rc, rs;
        logic [33:0] x2;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 64'(in_ready), 64'd1);
        @(negedge clk);

        chk_lat = 1'b1;
`ifdef SEG_PIPE_ADDER_SAT_EN
        x2 = {2'b10, 32'h7FFF_FFFF};
`else
        x2 = {2'b10, 32'h8000_0000};
`endif
        tick(1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, {2'b01, 32'h0}, acc);
        tick(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1, x2, acc);
        tick(1'b1, 32'd5, 32'd7, 1'b0, 1'b1, 1'b1, 1'b1, {2'b00, 32'hFFFF_FFFE}, acc);
        tick(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, {2'b01, 32'h0}, acc);
        idle(6);
        chk("directed_drained", 64'(q.size()), 64'd0);

        chk_lat = 1'b0;
        n = 0;
        guard = 0;
        ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
        while (n < 64 && guard < 2000) begin
            tick(1'b1, ra, rb, rc, rs, 1'($urandom_range(0, 1)), 1'b0, '0, acc);
            guard++;
            if (acc) begin
                n++;
                ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
            end
        end
        chk("stream_accepted", 64'(n), 64'd64);
        idle(10);
        chk("stream_drained", 64'(q.size()), 64'd0);
        chk("stream_idle_valid", 64'(out_valid), 64'd0);

        chk_lat = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1, 1'b0, '0, acc);
            idle(2);
        end
        idle(6);
        chk("bubble_drained", 64'(q.size()), 64'd0);

        for (int i = 0; i < 6; i++)
            tick(1'b1, $urandom, $urandom, 1'($urandom), 1'b0, 1'b1, 1'b0, '0, acc);
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_sum", 64'(sum), 64'd0);
        chk("midreset_cout", 64'(cout), 64'd0);
        chk("midreset_ovf", 64'(ovf), 64'd0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(8);
        tick(1'b1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b1, 1'b1, {2'b00, 32'd5}, acc);
        idle(6);
        chk("final_drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_pipe_adder.md
Name: seg_pipe_adder

Overview:
- Parametrised, pipelined successor to the team's combinational 32-bit adder.
- Splits a WIDTH-bit add/subtract into NSEG = WIDTH/SEG segments; one segment is resolved per pipeline stage, with the carry registered between stages.
- Accepts one operation per cycle under a valid/ready handshake and adds carry-in, subtract mode, carry-out and signed-overflow outputs.
- Sits in the datapath where a full-width single-cycle carry chain misses timing.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SEG, 8, segment width in bits. WIDTH % SEG == 0 is required; an elaboration-time check fails otherwise.
- NSEG, WIDTH/SEG, derived localparam: number of pipeline stages, equal to the latency.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  1: compute a - b as a + ~b + 1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  unsigned carry out of the MSB. For subtract, 1 means no borrow.
- ovf  out  1  signed overflow: carry into the MSB XOR carry out of the MSB.

Behaviour:
- Reset: asynchronous and active-high; one clock (clk). While reset is high:
  - all stage valid bits clear;
  - out_valid=0, sum=0, cout=0, ovf=0;
  - in_ready=1 once reset deasserts.
- Global advance enable: en = !out_valid || out_ready.
  - in_ready = en.
  - Transfer in occurs when in_valid && in_ready.
  - Transfer out occurs when out_valid && out_ready.
- When en=1, every stage shifts forward by one. A stage with no valid data passes a bubble (valid=0); bubbles are not collapsed.
- When en=0, all stages hold their data.
- Stage k (0..NSEG-1):
  - adds segment k of a and of b_eff (b_eff = sub ? ~b : b) plus the carry from stage k-1;
  - stage 0 carry-in is sub ? 1 : cin;
  - stores SEG result bits and registers the segment carry out;
  - higher, unprocessed segments of a and b_eff travel with the operation (skew registers);
  - completed low segments of the result travel forward.
- Latency: a result appears on out_valid exactly NSEG cycles after acceptance when not stalled. Throughput is one result per cycle.
- Results are in acceptance order; none is lost or duplicated under any out_ready pattern.
- Result arithmetic:
  - sum = (a + b_eff + c0) mod 2^WIDTH;
  - cout = bit WIDTH of the unmodded result;
  - ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- NSEG=1 degenerates to a single registered adder with latency 1.
- Reset mid-operation: all in-flight operations are discarded immediately. No stale result ever appears after reset deassertion.
- in_valid while in_ready=0 is ignored. The upstream must hold its operands.

Optional Feature:
- Macro: SEG_PIPE_ADDER_SAT_EN.
- Defined: when ovf=1, the final stage replaces sum with a signed saturated value:
  - 0 followed by all 1s (max positive) if a[MSB]=0;
  - 1 followed by all 0s (min negative) if a[MSB]=1.
  - cout and ovf are reported unchanged.
  - Requires carrying a[MSB] and b_eff[MSB] to the last stage.
- Undefined: sum wraps modulo 2^WIDTH. No MSB skew bits beyond those needed for ovf.

Decomposition:
- Package seg_pipe_adder_pkg holds:
  - default WIDTH and SEG;
  - a function returning the saturation constants for a given width;
  - a function computing NSEG.
- Sub-module seg_adder_stage (SEG-bit add with carry in/out, enable-gated registers) is instantiated NSEG times by a generate loop.
- Skew and valid registers live in the top module.

Test Plan:
All scenarios use WIDTH=32, SEG=8, latency 4.
1. Carry ripple: a=0x0000_0001, b=0xFFFF_FFFF, sub=0, cin=0 -> 4 cycles later sum=0x0000_0000, cout=1, ovf=0.
2. Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001 -> sum=0x8000_0000, ovf=1, cout=0. With SEG_PIPE_ADDER_SAT_EN defined, sum=0x7FFF_FFFF and ovf=1.
3. Subtract and carry-in:
   - a=5, b=7, sub=1, cin=0 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
   - a=0xFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1.
4. Streaming with backpressure: 64 random operand pairs, in_valid always high, out_ready random 50% -> scoreboard matches a+b in order. in_ready=0 exactly when out_valid=1 and out_ready=0. No drop or duplicate.
5. Bubbles: in_valid pulses every third cycle, out_ready=1 -> each result appears exactly 4 cycles after its acceptance, with out_valid low between results.
6. Reset mid-flight: 3 operations in flight, reset asserted asynchronously between edges -> out_valid=0 and sum=0 before the next edge. After deassertion, no old results appear, and a fresh a=2, b=3 yields 5 after 4 cycles.
